// File: rtl/pc_stack_nibble_param.sv
// Nibble-serial program counter with a circular return-address stack.
// The PC is streamed onto the 4-bit bus one nibble per fetch cycle and
// incremented nibble-serially with a carry flop; execute cycles may
// overwrite single nibbles or push/pop the return stack.
module pc_stack_nibble_param #(
  parameter int NIBBLES = 3,
  parameter int DEPTH   = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   halt,
  input  logic [2:0]             cycle,
  input  logic [3:0]             data,
  input  logic [3:0]             regval,
  input  logic [3:0]             inst_operand,
  input  logic [1:0]             pc_next_sel,
  input  logic [NIBBLES-1:0]     pc_write_enable,
  input  logic [1:0]             stack_op,
  input  logic                   flag_clear,
  output logic                   pc_enable,
  output logic [3:0]             pc_word,
  output logic [4*NIBBLES-1:0]   pc_value,
  output logic [3:0]             stack_depth,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int              PCW       = 4 * NIBBLES;
  localparam logic [2:0]      CYC_IDLE  = 3'(NIBBLES);
  localparam logic [3:0]      DEPTH_MAX = 4'(DEPTH);
  localparam logic [2:0]      SP_LAST   = 3'(DEPTH - 1);
  localparam logic [NIBBLES-1:0] ONE_N  = {{(NIBBLES-1){1'b0}}, 1'b1};

  logic [PCW-1:0] pc_q, pc_d;
  logic           carry_q, carry_d;
  logic [PCW-1:0] stack_q [DEPTH];
  logic [PCW-1:0] stack_d [DEPTH];
  logic [2:0]     sp_q, sp_d;
  logic [3:0]     depth_q, depth_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic               exec_phase;
  logic               do_push;
  logic               do_pop;
  logic               do_write;
  logic [3:0]         src_nib;
  logic [NIBBLES-1:0] we_low;
  logic [2:0]         sp_inc;
  logic [2:0]         sp_dec;
  logic [PCW-1:0]     pop_val;
  logic [4:0]         nib_sum;

  // Bus-side decode: PC nibble during fetch, idle slot, then released.
  always_comb begin
    pc_enable = (cycle <= CYC_IDLE);
    pc_word   = 4'd0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (cycle == 3'(k)) pc_word = pc_q[4*k +: 4];
    end
  end

  // Execute-phase decode: source mux, lowest write bit, stack pointer arithmetic.
  always_comb begin
    exec_phase = (cycle > CYC_IDLE);
    do_push    = exec_phase && (stack_op == 2'd1);
    do_pop     = exec_phase && (stack_op == 2'd2);
    do_write   = exec_phase && (pc_next_sel != 2'd3) && !do_pop;
    case (pc_next_sel)
      2'd0:    src_nib = data;
      2'd1:    src_nib = regval;
      default: src_nib = inst_operand;
    endcase
    we_low  = pc_write_enable & (~pc_write_enable + ONE_N);
    sp_inc  = (sp_q == SP_LAST) ? 3'd0 : sp_q + 3'd1;
    sp_dec  = (sp_q == 3'd0) ? SP_LAST : sp_q - 3'd1;
    pop_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_dec == 3'(i)) pop_val = stack_q[i];
    end
  end

  // Next-state: increment, nibble write, push/pop and sticky flags; halt freezes all.
  always_comb begin
    pc_d    = pc_q;
    carry_d = carry_q;
    stack_d = stack_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    nib_sum = 5'd0;
    if (!halt) begin
      if (flag_clear) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      for (int k = 0; k < NIBBLES; k++) begin
        if (cycle == 3'(k)) begin
          nib_sum = {1'b0, pc_q[4*k +: 4]} + ((k == 0) ? 5'd1 : {4'd0, carry_q});
          pc_d[4*k +: 4] = nib_sum[3:0];
          carry_d = (k == NIBBLES - 1) ? 1'b0 : nib_sum[4];
        end
      end
      if (do_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (sp_q == 3'(i)) stack_d[i] = pc_q;
        end
        sp_d = sp_inc;
        if (depth_q == DEPTH_MAX) ovf_d = 1'b1;
        else                      depth_d = depth_q + 4'd1;
      end
      if (do_pop) begin
        pc_d = pop_val;
        sp_d = sp_dec;
        if (depth_q == 4'd0) unf_d = 1'b1;
        else                 depth_d = depth_q - 4'd1;
      end else if (do_write) begin
        for (int j = 0; j < NIBBLES; j++) begin
          if (we_low[j]) pc_d[4*j +: 4] = src_nib;
        end
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= '0;
      carry_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      sp_q    <= 3'd0;
      depth_q <= 4'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      carry_q <= carry_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pc_value    = pc_q;
  assign stack_depth = depth_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: doc/pc_stack_nibble_param.md
Name: pc_stack_nibble_param

Overview:
- Parametrised successor to the nibble-serial program counter of the 4-bit CPU.
- PC width is NIBBLES×4 bits; it is streamed one nibble per cycle onto the bus and incremented nibble-serially with carry.
- Adds a DEPTH-entry return-address stack (push on subroutine call, pop on return) with wrap-around and sticky overflow/underflow flags.
- Sits between the instruction decoder/cycle sequencer and the shared 4-bit data bus.

Parameters:
- NIBBLES, 3, PC width in nibbles (legal 2..4; PC is 4*NIBBLES bits).
- DEPTH, 3, return-stack entries (legal 1..8).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- halt  in  1  freezes all state when high.
- cycle  in  3  machine-cycle index from the sequencer.
- data  in  4  bus nibble (PC source 0).
- regval  in  4  register-file nibble (PC source 1).
- inst_operand  in  4  instruction operand nibble (PC source 2).
- pc_next_sel  in  2  0=data, 1=regval, 2=inst_operand, 3=reserved.
- pc_write_enable  in  NIBBLES  one-hot nibble write select.
- stack_op  in  2  0=none, 1=push, 2=pop, 3=reserved (treated as none).
- flag_clear  in  1  clears the sticky flags.
- pc_enable  out  1  PC nibble is driven on the bus this cycle.
- pc_word  out  4  PC nibble for the bus.
- pc_value  out  4*NIBBLES  full PC (debug).
- stack_depth  out  4  number of valid stack entries (0..DEPTH).
- overflow  out  1  sticky: push made at full depth.
- underflow  out  1  sticky: pop made at empty.

Behaviour:
- Reset (async, reset_n low):
  - PC, carry, all stack entries, stack pointer, stack_depth, overflow and underflow are cleared to 0.
  - Outputs during reset: pc_value=0, stack_depth=0, flags=0; pc_word and pc_enable still follow the cycle decode.
  - Reset asserted mid-increment or mid-write aborts the operation; nothing partial survives.
- halt=1: no register changes, including flags. The combinational outputs still track cycle.
- Fetch/increment phase, cycle k with k<NIBBLES:
  - pc_enable=1; pc_word = PC nibble k, showing the pre-increment value.
  - At the clock edge: k=0 → {carry, nib0} <= nib0+1. 0<k<NIBBLES → {carry, nib k} <= nib k + carry.
  - At k=NIBBLES-1 the carry out is discarded and carry cleared, so all-ones wraps to 0.
- cycle == NIBBLES: pc_enable=1, pc_word=0 (bus-idle slot). No state change.
- cycle > NIBBLES (execute phase): pc_enable=0, pc_word=0.
- Nibble write in the execute phase:
  - Nibble j <= selected source when pc_write_enable[j]=1.
  - If multiple bits are set, only the lowest-index bit is honoured.
  - pc_next_sel=3 suppresses the write.
  - Writes are ignored when cycle<=NIBBLES.
- Stack, execute phase only (stack_op ignored when cycle<=NIBBLES):
  - push: stack[sp] <= PC (value before any same-cycle write); sp <= (sp+1) mod DEPTH; stack_depth saturates at DEPTH.
  - Push at depth==DEPTH overwrites the oldest entry (circular) and sets overflow.
  - pop: PC <= stack[(sp-1) mod DEPTH]; sp <= (sp-1) mod DEPTH; stack_depth decrements, floor 0.
  - Pop at depth 0 still loads that entry (circular wrap), sets underflow, and depth stays 0.
- Simultaneous events:
  - push + pc_write same cycle: push saves the old PC and the write applies.
  - pop + pc_write same cycle: pop wins; the write is dropped.
  - flag_clear with a new flag event in the same cycle: the set wins.
- The return address is the already-incremented PC. The sequencer issues push in the execute phase of the call instruction, then writes the target nibbles in later execute cycles.

Test Plan (NIBBLES=3, DEPTH=3):
- Reset, then 3 fetch windows (cycles 0..7) → pc_word seq 0,0,0 then 1,0,0 then 2,0,0; pc_value=0x003; pc_enable=1 on cycles 0-3 only.
- Preload PC=0x0FF, run cycles 0..2 → pc_value=0x100. Preload 0xFFF → wraps to 0x000, carry=0.
- PC=0x123; cycle 4 push with sel=2, inst_operand=5, we=001 → stack[0]=0x123, PC=0x125, depth=1. Later pop → PC=0x123, depth=0.
- Four pushes of 0x010,0x020,0x030,0x040 → overflow=1, depth=3. Pops return 0x040, 0x030, 0x020; a 4th pop sets underflow=1 and loads 0x040.
- halt=1 across a full cycle 0..7 sequence with push and writes → pc_value, depth and flags unchanged. Drop reset_n mid-cycle-1 → pc_value=0 immediately, without waiting for a clock edge.
- pop + we=010 in the same cycle → PC = popped value, nibble 1 not overwritten. flag_clear with no event → flags 0.
